// File: rtl/core_dmem_bridge_pkg.sv
// Shared definitions for the LSU-to-memory-bus bridge: default memory widths
// and the bridge FSM state encoding.
package core_dmem_bridge_pkg;

    localparam int CORE_MEM_AW = 64;
    localparam int CORE_MEM_DW = 64;
    localparam int CORE_MEM_SW = CORE_MEM_DW / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RSP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } dmem_state_e;

endpackage

// File: rtl/core_dmem_bridge_timer.sv
// Response timeout counter: counts cycles while active, restarts from zero on
// every new active period, and flags the LIMIT-th active cycle.
module core_dmem_bridge_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (active) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of active cycles already completed
    assign expired = active && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/core_dmem_bridge.sv
// Single-outstanding LSU port to split-transaction (req/gnt + valid/ready) bus bridge.
// Optional response timeout with post-timeout drain: define CORE_DMEM_TIMEOUT_EN.
module core_dmem_bridge
    import core_dmem_bridge_pkg::*;
#(
    parameter int AW             = CORE_MEM_AW,
    parameter int DW             = CORE_MEM_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              dmem_req,
    input  logic [AW-1:0]     dmem_addr,
    input  logic              dmem_wen,
    input  logic [DW/8-1:0]   dmem_strb,
    input  logic [DW-1:0]     dmem_wdata,
    output logic              dmem_gnt,
    output logic              dmem_err,
    output logic [DW-1:0]     dmem_rdata,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [DW/8-1:0]   mem_strb,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic              mem_rsp_err,
    input  logic [DW-1:0]     mem_rsp_rdata
);

    localparam int SW = DW / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("core_dmem_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    dmem_state_e   state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          wen_q,   wen_d;
    logic [SW-1:0] strb_q,  strb_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q,   err_d;

`ifdef CORE_DMEM_TIMEOUT_EN
    logic drain_q, drain_d;
    logic timeout;

    core_dmem_bridge_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (g_clk),
        .rst     (g_reset),
        .active  (state_q == ST_RSP),
        .expired (timeout)
    );
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef CORE_DMEM_TIMEOUT_EN
        drain_d = drain_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    addr_d  = dmem_addr;
                    wen_d   = dmem_wen;
                    strb_d  = dmem_strb;
                    wdata_d = dmem_wdata;
                    state_d = ST_REQ;
                end
            end
            // The bus forbids withdrawing a request, so an LSU flush is ignored here
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    if (dmem_req) begin
                        rdata_d = mem_rsp_rdata;
                        err_d   = mem_rsp_err;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef CORE_DMEM_TIMEOUT_EN
                else if (timeout) begin
                    drain_d = 1'b1;
                    if (dmem_req) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
`endif
            end
            ST_DONE: begin
`ifdef CORE_DMEM_TIMEOUT_EN
                state_d = drain_q ? ST_DRAIN : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef CORE_DMEM_TIMEOUT_EN
            // Swallow the one late response still owed by the bus after a timeout
            ST_DRAIN: begin
                if (mem_rsp_valid) begin
                    drain_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef CORE_DMEM_TIMEOUT_EN
            drain_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef CORE_DMEM_TIMEOUT_EN
            drain_q <= drain_d;
`endif
        end
    end

    assign dmem_gnt   = (state_q == ST_DONE);
    assign dmem_err   = err_q;
    assign dmem_rdata = rdata_q;
    assign mem_req    = (state_q == ST_REQ);
    assign mem_addr   = addr_q;
    assign mem_wen    = wen_q;
    assign mem_strb   = strb_q;
    assign mem_wdata  = wdata_q;
`ifdef CORE_DMEM_TIMEOUT_EN
    assign mem_rsp_ready = (state_q == ST_RSP) || (state_q == ST_DRAIN);
`else
    assign mem_rsp_ready = (state_q == ST_RSP);
`endif

endmodule
